// File: rtl/mxint_act_pkg.sv
// Shared types and helpers for the MXINT activation / renormalisation datapath.
// The activation mode enum, a leading-sign counter and the exponent floor all live here.
package mxint_act_pkg;

    typedef enum logic [1:0] {
        BYPASS = 2'd0,
        RELU   = 2'd1,
        LEAKY  = 2'd2
    } act_mode_t;

    // Widest mantissa the leading-sign counter can inspect.
    localparam int unsigned MaxManWidth = 64;

    // Raw mode 3 is not a distinct activation and behaves as ReLU.
    function automatic act_mode_t decode_mode(input logic [1:0] raw);
        case (raw)
            2'd0:    return BYPASS;
            2'd2:    return LEAKY;
            default: return RELU;
        endcase
    endfunction

    // Number of bits below the sign bit that equal it, i.e. how far a
    // width-bit two's complement value can be left-shifted without overflow.
    function automatic int unsigned redundant_sign_bits(input logic [MaxManWidth-1:0] x,
                                                        input int unsigned width);
        int unsigned cnt;
        logic        done;
        cnt  = 0;
        done = 1'b0;
        for (int i = int'(width) - 2; i >= 0; i--) begin
            if (!done && (x[i] == x[width-1])) begin
                cnt++;
            end else begin
                done = 1'b1;
            end
        end
        return cnt;
    endfunction

    // Most negative exponent representable in an ew-bit two's complement field.
    function automatic int exp_min(input int unsigned ew);
        return -(32'sd1 <<< (ew - 1));
    endfunction

endpackage

// File: rtl/mxint_block_normalise.sv
// Stage 2: left-shifts a whole MXINT block by its common headroom and lowers the
// shared exponent to match, behind a single valid/ready register slice.
module mxint_block_normalise
    import mxint_act_pkg::*;
#(
    parameter int unsigned MAN_WIDTH  = 8,
    parameter int unsigned EXP_WIDTH  = 4,
    parameter int unsigned BLOCK_SIZE = 4,
    parameter int unsigned NORMALISE  = 1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [MAN_WIDTH*BLOCK_SIZE-1:0] in_man,
    input  logic [EXP_WIDTH-1:0]            in_exp,
    input  logic                            in_last,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [MAN_WIDTH*BLOCK_SIZE-1:0] out_man,
    output logic [EXP_WIDTH-1:0]            out_exp,
    output logic                            out_last
);

    logic [MAN_WIDTH-1:0]            elem;
    logic [MAN_WIDTH*BLOCK_SIZE-1:0] norm_man;
    logic [EXP_WIDTH-1:0]            norm_exp;
    logic                            all_zero;
    int unsigned                     r;
    int unsigned                     k_min;
    int                              headroom;
    int                              shift;

    logic                            valid_q;
    logic                            last_q;
    logic [MAN_WIDTH*BLOCK_SIZE-1:0] man_q;
    logic [EXP_WIDTH-1:0]            exp_q;

    always_comb begin
        elem     = '0;
        r        = 0;
        k_min    = MAN_WIDTH - 1;
        all_zero = 1'b1;
        for (int i = 0; i < BLOCK_SIZE; i++) begin
            elem = in_man[i*MAN_WIDTH +: MAN_WIDTH];
            r    = redundant_sign_bits(MaxManWidth'(elem), MAN_WIDTH);
            if (r < k_min) begin
                k_min = r;
            end
            if (elem != '0) begin
                all_zero = 1'b0;
            end
        end

        // Never push the exponent below its most negative encoding.
        headroom = int'(signed'(in_exp)) - exp_min(EXP_WIDTH);
        shift    = int'(k_min);
        if (shift > headroom) begin
            shift = headroom;
        end
        if (all_zero || (NORMALISE == 0)) begin
            shift = 0;
        end

        norm_man = '0;
        for (int i = 0; i < BLOCK_SIZE; i++) begin
            norm_man[i*MAN_WIDTH +: MAN_WIDTH] = in_man[i*MAN_WIDTH +: MAN_WIDTH] << shift;
        end
        norm_exp = in_exp - EXP_WIDTH'(shift);
    end

    assign in_ready = !valid_q || out_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            man_q   <= '0;
            exp_q   <= '0;
        end else if (in_ready) begin
            valid_q <= in_valid;
            if (in_valid) begin
                man_q  <= norm_man;
                exp_q  <= norm_exp;
                last_q <= in_last;
            end
        end
    end

    assign out_valid = valid_q;
    assign out_man   = man_q;
    assign out_exp   = exp_q;
    assign out_last  = last_q;

endmodule

// File: rtl/mxint_activation_norm.sv
// Streaming MXINT activation (bypass / ReLU / leaky-ReLU) with optional block
// renormalisation; tracks tensor tiling and tags the final block of each tensor.
module mxint_activation_norm
    import mxint_act_pkg::*;
#(
    parameter int unsigned MAN_WIDTH         = 8,
    parameter int unsigned EXP_WIDTH         = 4,
    parameter int unsigned PARALLELISM_DIM_0 = 2,
    parameter int unsigned PARALLELISM_DIM_1 = 2,
    parameter int unsigned TENSOR_SIZE_DIM_0 = 4,
    parameter int unsigned TENSOR_SIZE_DIM_1 = 4,
    parameter int unsigned LEAKY_SHIFT       = 2,
    parameter int unsigned NORMALISE         = 1,
    localparam int unsigned BLOCK_SIZE       = PARALLELISM_DIM_0 * PARALLELISM_DIM_1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [1:0]                      mode,
    input  logic [MAN_WIDTH*BLOCK_SIZE-1:0] mdata_in,
    input  logic [EXP_WIDTH-1:0]            edata_in,
    input  logic                            data_in_valid,
    output logic                            data_in_ready,
    output logic [MAN_WIDTH*BLOCK_SIZE-1:0] mdata_out,
    output logic [EXP_WIDTH-1:0]            edata_out,
    output logic                            data_out_valid,
    input  logic                            data_out_ready,
    output logic                            data_out_last
);

    localparam int unsigned NUM_TILES = (TENSOR_SIZE_DIM_0 / PARALLELISM_DIM_0) *
                                        (TENSOR_SIZE_DIM_1 / PARALLELISM_DIM_1);
    localparam int unsigned TILE_W    = (NUM_TILES > 1) ? $clog2(NUM_TILES) : 1;
    localparam int unsigned BW        = MAN_WIDTH * BLOCK_SIZE;

    logic [TILE_W-1:0]           tile_q;
    logic                        tile_first;
    logic                        tile_last;
    act_mode_t                   mode_q;
    act_mode_t                   eff_mode;

    logic signed [MAN_WIDTH-1:0] elem;
    logic [BW-1:0]               act_man;

    logic                        in_fire;
    logic                        s1_valid_q;
    logic                        s1_last_q;
    logic [BW-1:0]               s1_man_q;
    logic [EXP_WIDTH-1:0]        s1_exp_q;
    logic                        s2_ready;

    assign tile_first    = (tile_q == '0);
    assign tile_last     = (tile_q == TILE_W'(NUM_TILES - 1));
    assign data_in_ready = !s1_valid_q || s2_ready;
    assign in_fire       = data_in_valid && data_in_ready;

    // The first block of a tensor uses the live mode; the rest reuse the latched copy.
    assign eff_mode = tile_first ? decode_mode(mode) : mode_q;

    always_comb begin
        elem    = '0;
        act_man = '0;
        for (int i = 0; i < BLOCK_SIZE; i++) begin
            elem = mdata_in[i*MAN_WIDTH +: MAN_WIDTH];
            act_man[i*MAN_WIDTH +: MAN_WIDTH] = elem;
            if (elem[MAN_WIDTH-1]) begin
                case (eff_mode)
                    RELU:    act_man[i*MAN_WIDTH +: MAN_WIDTH] = '0;
                    LEAKY:   act_man[i*MAN_WIDTH +: MAN_WIDTH] = elem >>> LEAKY_SHIFT;
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid_q <= 1'b0;
            s1_last_q  <= 1'b0;
            s1_man_q   <= '0;
            s1_exp_q   <= '0;
            tile_q     <= '0;
            mode_q     <= BYPASS;
        end else begin
            if (data_in_ready) begin
                s1_valid_q <= data_in_valid;
            end
            if (in_fire) begin
                s1_man_q  <= act_man;
                s1_exp_q  <= edata_in;
                s1_last_q <= tile_last;
                tile_q    <= tile_last ? '0 : tile_q + TILE_W'(1);
                if (tile_first) begin
                    mode_q <= eff_mode;
                end
            end
        end
    end

    mxint_block_normalise #(
        .MAN_WIDTH  (MAN_WIDTH),
        .EXP_WIDTH  (EXP_WIDTH),
        .BLOCK_SIZE (BLOCK_SIZE),
        .NORMALISE  (NORMALISE)
    ) u_normalise (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (s1_valid_q),
        .in_ready  (s2_ready),
        .in_man    (s1_man_q),
        .in_exp    (s1_exp_q),
        .in_last   (s1_last_q),
        .out_valid (data_out_valid),
        .out_ready (data_out_ready),
        .out_man   (mdata_out),
        .out_exp   (edata_out),
        .out_last  (data_out_last)
    );

endmodule

// File: tb/tb_mxint_activation_norm.sv
// Bench for mxint_activation_norm: directed vectors, mode-latch and mid-tensor reset
// sequences, then randomised traffic with backpressure against an integer reference.
module tb_mxint_activation_norm;

    localparam int W  = 8;
    localparam int E  = 4;
    localparam int BS = 4;
    localparam int NT = 4;
    localparam int LS = 2;
    localparam int BW = W * BS;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [1:0]    mode = 2'd0;
    logic [BW-1:0] mdata_in = '0;
    logic [E-1:0]  edata_in = '0;
    logic          data_in_valid = 1'b0;
    logic          data_out_ready = 1'b1;
    logic          data_in_ready, data_out_valid, data_out_last;
    logic [BW-1:0] mdata_out;
    logic [E-1:0]  edata_out;
    logic          raw_in_ready, raw_valid, raw_last;
    logic [BW-1:0] raw_mdata;
    logic [E-1:0]  raw_edata;

    always #5 clk = ~clk;

    mxint_activation_norm #(
        .MAN_WIDTH(W), .EXP_WIDTH(E), .PARALLELISM_DIM_0(2), .PARALLELISM_DIM_1(2),
        .TENSOR_SIZE_DIM_0(4), .TENSOR_SIZE_DIM_1(4), .LEAKY_SHIFT(LS), .NORMALISE(1)
    ) dut (
        .clk(clk), .rst(rst), .mode(mode), .mdata_in(mdata_in), .edata_in(edata_in),
        .data_in_valid(data_in_valid), .data_in_ready(data_in_ready),
        .mdata_out(mdata_out), .edata_out(edata_out), .data_out_valid(data_out_valid),
        .data_out_ready(data_out_ready), .data_out_last(data_out_last)
    );

    mxint_activation_norm #(
        .MAN_WIDTH(W), .EXP_WIDTH(E), .PARALLELISM_DIM_0(2), .PARALLELISM_DIM_1(2),
        .TENSOR_SIZE_DIM_0(4), .TENSOR_SIZE_DIM_1(4), .LEAKY_SHIFT(LS), .NORMALISE(0)
    ) dut_raw (
        .clk(clk), .rst(rst), .mode(mode), .mdata_in(mdata_in), .edata_in(edata_in),
        .data_in_valid(data_in_valid), .data_in_ready(raw_in_ready),
        .mdata_out(raw_mdata), .edata_out(raw_edata), .data_out_valid(raw_valid),
        .data_out_ready(data_out_ready), .data_out_last(raw_last)
    );

    typedef struct {
        logic [BW-1:0] m_norm;
        logic [E-1:0]  e_norm;
        logic [BW-1:0] m_raw;
        logic [E-1:0]  e_raw;
        logic          last;
    } exp_t;

    typedef struct {
        logic [1:0] md;
        logic [E-1:0] e;
        int m[BS];
        int xn[BS];
        logic [E-1:0] xe;
        int xr[BS];
    } vec_t;

    int   total = 0;
    int   bad = 0;
    exp_t sb[$];
    exp_t want;
    int   m_tile = 0;
    int   m_mode = 0;
    int   last_seen = 0;
    bit   sb_en = 1'b0;
    bit   rand_rdy = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    function automatic int elem(input logic [BW-1:0] mb, input int i);
        logic signed [W-1:0] v;
        v = mb[i*W +: W];
        return int'(v);
    endfunction

    function automatic logic [BW-1:0] pack(input int a[BS]);
        logic [BW-1:0] p;
        for (int i = 0; i < BS; i++) p[i*W +: W] = W'(a[i]);
        return p;
    endfunction

    function automatic int activate(input int x, input int md);
        int d;
        d = 1 << LS;
        if (x >= 0 || md == 0) return x;
        if (md == 2) return -((-x + d - 1) / d);
        return 0;
    endfunction

    // Reference: largest shift that keeps every element in range, capped by exponent floor.
    function automatic exp_t model(input int md, input logic [E-1:0] eb, input logic [BW-1:0] mb,
                                   input bit last);
        exp_t r;
        int s[BS];
        int e, k, lim, v;
        bit allz, fits;
        logic signed [E-1:0] es;
        es = eb;
        e = int'(es);
        allz = 1'b1;
        for (int i = 0; i < BS; i++) begin
            s[i] = activate(elem(mb, i), md);
            if (s[i] != 0) allz = 1'b0;
        end
        k = 0;
        for (int t = 1; t < W; t++) begin
            fits = 1'b1;
            for (int i = 0; i < BS; i++) begin
                v = s[i] * (1 << t);
                if (v > (1 << (W - 1)) - 1 || v < -(1 << (W - 1))) fits = 1'b0;
            end
            if (fits && k == t - 1) k = t;
        end
        lim = e + (1 << (E - 1));
        if (k > lim) k = lim;
        if (allz) k = 0;
        for (int i = 0; i < BS; i++) begin
            r.m_raw[i*W +: W]  = W'(s[i]);
            r.m_norm[i*W +: W] = W'(s[i] * (1 << k));
        end
        r.e_raw  = eb;
        r.e_norm = E'(e - k);
        r.last   = last;
        return r;
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            sb.delete();
            m_tile = 0;
            last_seen = 0;
        end else if (sb_en) begin
            if (data_out_valid && data_out_ready) begin
                if (data_out_last) last_seen++;
                if (sb.size() == 0) begin
                    check("sb_unexpected_output", 64'd1, 64'd0);
                end else begin
                    want = sb.pop_front();
                    check("sb_man", mdata_out, want.m_norm);
                    check("sb_exp", edata_out, want.e_norm);
                    check("sb_last", data_out_last, want.last);
                    check("sb_raw_valid", raw_valid, 1'b1);
                    check("sb_raw_man", raw_mdata, want.m_raw);
                    check("sb_raw_exp", raw_edata, want.e_raw);
                    check("sb_raw_last", raw_last, want.last);
                end
            end
            if (data_in_valid && data_in_ready) begin
                if (m_tile == 0) m_mode = (mode == 2'd0) ? 0 : (mode == 2'd2) ? 2 : 1;
                sb.push_back(model(m_mode, edata_in, mdata_in, m_tile == NT - 1));
                m_tile = (m_tile + 1) % NT;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_rdy) data_out_ready = ($urandom_range(0, 2) != 0);
    endtask

    task automatic do_reset();
        data_in_valid = 1'b0;
        rst = 1'b0;
        #2;
        check("rst_valid", data_out_valid, 1'b0);
        check("rst_man", mdata_out, '0);
        check("rst_exp", edata_out, '0);
        check("rst_last", data_out_last, 1'b0);
        check("rst_raw_valid", raw_valid, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("rst_in_ready", data_in_ready, 1'b1);
    endtask

    task automatic send(input logic [1:0] md, input logic [E-1:0] e, input logic [BW-1:0] m);
        bit acc;
        acc = 1'b0;
        mode = md;
        edata_in = e;
        mdata_in = m;
        data_in_valid = 1'b1;
        for (int c = 0; c < 100 && !acc; c++) begin
            @(negedge clk);
            acc = data_in_ready;
            tick();
        end
        data_in_valid = 1'b0;
        if (!acc) check("send_timeout", 64'd0, 64'd1);
    endtask

    task automatic drain();
        int c;
        c = 0;
        while (sb.size() != 0 && c < 400) begin
            tick();
            c++;
        end
        check("drain_empty", sb.size(), 0);
    endtask

    vec_t vecs[8];

    initial begin
        vecs[0] = '{2'd1, 4'd2, '{-3, 5, 12, -128}, '{0, 40, 96, 0}, 4'hF, '{0, 5, 12, 0}};
        vecs[1] = '{2'd2, 4'd0, '{-8, -3, 4, 0}, '{-32, -16, 64, 0}, 4'hC, '{-2, -1, 4, 0}};
        vecs[2] = '{2'd1, 4'h9, '{1, 0, 0, 0}, '{2, 0, 0, 0}, 4'h8, '{1, 0, 0, 0}};
        vecs[3] = '{2'd1, 4'd3, '{0, 0, 0, 0}, '{0, 0, 0, 0}, 4'd3, '{0, 0, 0, 0}};
        vecs[4] = '{2'd0, 4'd5, '{-100, 77, -1, 3}, '{-100, 77, -1, 3}, 4'd5, '{-100, 77, -1, 3}};
        vecs[5] = '{2'd3, 4'd1, '{-5, 6, -7, 1}, '{0, 96, 0, 16}, 4'hD, '{0, 6, 0, 1}};
        vecs[6] = '{2'd2, 4'h8, '{-1, 64, 0, 0}, '{-1, 64, 0, 0}, 4'h8, '{-1, 64, 0, 0}};
        vecs[7] = '{2'd0, 4'd7, '{-1, -1, -1, -1}, '{-128, -128, -128, -128}, 4'd0,
                    '{-1, -1, -1, -1}};

        do_reset();

        // Directed vectors: one block per fresh tensor, exact two-cycle latency.
        for (int i = 0; i < 8; i++) begin
            do_reset();
            data_out_ready = 1'b1;
            mode = vecs[i].md;
            edata_in = vecs[i].e;
            mdata_in = pack(vecs[i].m);
            data_in_valid = 1'b1;
            @(posedge clk);
            #1;
            data_in_valid = 1'b0;
            check($sformatf("vec%0d_lat1_valid", i), data_out_valid, 1'b0);
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_lat2_valid", i), data_out_valid, 1'b1);
            check($sformatf("vec%0d_man", i), mdata_out, pack(vecs[i].xn));
            check($sformatf("vec%0d_exp", i), edata_out, vecs[i].xe);
            check($sformatf("vec%0d_last", i), data_out_last, 1'b0);
            check($sformatf("vec%0d_raw_man", i), raw_mdata, pack(vecs[i].xr));
            check($sformatf("vec%0d_raw_exp", i), raw_edata, vecs[i].e);
        end

        // Mode latch: ReLU on tile 0 must hold even when mode flips to bypass.
        do_reset();
        sb_en = 1'b1;
        data_out_ready = 1'b1;
        send(2'd1, 4'd0, {4{8'hFC}});
        send(2'd0, 4'd0, {4{8'hFC}});
        tick();
        check("latch_valid", data_out_valid, 1'b1);
        check("latch_man", mdata_out, '0);
        check("latch_raw_man", raw_mdata, '0);
        send(2'd0, 4'd0, {4{8'hFC}});
        send(2'd2, 4'd0, {4{8'hFC}});
        send(2'd0, 4'd1, {4{8'hFC}});
        tick();
        tick();
        check("next_tensor_raw_man", raw_mdata, {4{8'hFC}});
        drain();

        // Reset with blocks in flight: discarded, tile count restarts.
        data_out_ready = 1'b0;
        send(2'd1, 4'd2, {4{8'h11}});
        send(2'd1, 4'd2, {4{8'h22}});
        do_reset();
        data_out_ready = 1'b1;
        for (int i = 0; i < 4; i++) send(2'd2, 4'd0, {8'(i), 8'h80, 8'h03, 8'hF0});
        drain();
        check("post_reset_lasts", last_seen, 1);

        // Randomised traffic with pseudo-random backpressure.
        do_reset();
        rand_rdy = 1'b1;
        for (int n = 0; n < 48; n++) begin
            logic [BW-1:0] m;
            for (int i = 0; i < BS; i++) begin
                m[i*W +: W] = W'(($urandom_range(0, 255) - 128) >>> $urandom_range(0, 6));
            end
            if ($urandom_range(0, 3) == 0) tick();
            send(2'($urandom_range(0, 3)), E'($urandom_range(0, 15)), m);
        end
        drain();
        rand_rdy = 1'b0;
        data_out_ready = 1'b1;
        drain();
        check("random_lasts", last_seen, 12);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

endmodule

// File: doc/mxint_activation_norm.md
# mxint_activation_norm

Streaming MXINT activation unit with a run-time selectable mode (bypass, ReLU, leaky-ReLU) and optional block renormalisation. Each cycle it accepts one block of `BLOCK_SIZE` signed mantissas sharing one signed exponent, applies the activation element-wise, and optionally left-shifts the block to recover precision. It sits between MXINT linear/matmul layers and the next layer's input cast. It tracks tensor tiling and flags the last block of each tensor.

## Interface
- `MAN_WIDTH`, 8: mantissa width, two's complement.
- `EXP_WIDTH`, 4: shared exponent width, two's complement; value = m·2^e.
- `PARALLELISM_DIM_0`, 2: block width; `PARALLELISM_DIM_1`, 2: block height; `BLOCK_SIZE` = product.
- `TENSOR_SIZE_DIM_0`, 4 and `TENSOR_SIZE_DIM_1`, 4: tensor size. Each must be an exact multiple of its parallelism.
- `LEAKY_SHIFT`, 2: leaky slope is 2^-LEAKY_SHIFT, range 1..MAN_WIDTH-1.
- `NORMALISE`, 1: 1 enables the renormalisation stage; 0 passes stage-1 output through.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset. One clock; reset is asynchronous and active-low.
- `mode`  in  2  0 bypass, 1 ReLU, 2 leaky-ReLU, 3 treated as ReLU.
- `mdata_in`  in  MAN_WIDTH×BLOCK_SIZE  input mantissas.
- `edata_in`  in  EXP_WIDTH  input shared exponent.
- `data_in_valid` in 1, `data_in_ready` out 1: input handshake.
- `mdata_out`  out  MAN_WIDTH×BLOCK_SIZE  output mantissas.
- `edata_out`  out  EXP_WIDTH  output shared exponent.
- `data_out_valid` out 1, `data_out_ready` in 1: output handshake.
- `data_out_last`  out  1  qualifies the final block of a tensor; valid only with `data_out_valid`.

## Operation
- Mode latch: `mode` is sampled when the first block of a tensor is accepted (tile count 0) and held for that whole tensor. Mid-tensor changes to `mode` are ignored.
- Stage 1, per element:
  - bypass: x unchanged.
  - ReLU: negative x becomes 0.
  - leaky: negative x becomes x >>> LEAKY_SHIFT (arithmetic shift, floor).
  - Exponent passes through unchanged.
- Stage 2 (NORMALISE=1):
  - For each element, r_i = (count of leading bits equal to the sign bit) − 1. For zero, r = MAN_WIDTH−1.
  - k = min(r_i), then clamped to k ≤ e − (−2^(EXP_WIDTH−1)) so the exponent cannot underflow.
  - Outputs: m_i << k and e − k.
  - All-zero block: mantissas 0, exponent unchanged (k forced to 0).
- Stage 2 (NORMALISE=0): register only.
- Tile counter: counts accepted blocks 0..(TENSOR_SIZE_DIM_0/PAR0)·(TENSOR_SIZE_DIM_1/PAR1)−1, then wraps to 0. The last flag travels with its block through the pipeline.

## Timing
- Latency 2 cycles from input accept to `data_out_valid`. Throughput is 1 block/cycle when `data_out_ready` stays high.
- Valid/ready pipeline:
  - Each stage loads when it is empty or its successor is consuming.
  - `data_in_ready` = !s1_valid || s2 will accept this cycle. This is combinational from `data_out_ready`.
  - Data is held stable while valid && !ready. No block is dropped or duplicated.
- Simultaneous accept and emit in one cycle sustain full throughput.
- Reset (async assert, sync deassert):
  - all valids 0, tile counter 0, latched mode 0;
  - `mdata_out` 0, `edata_out` 0, `data_out_last` 0;
  - `data_in_ready` reads 1 once `rst` is deasserted.
- Reset mid-tensor discards in-flight blocks; the next accepted block is tile 0.

## Structure
- Package `mxint_act_pkg`: `act_mode_t` enum (BYPASS, RELU, LEAKY), the `redundant_sign_bits` function, and the exponent-min constant helper.
- Sub-module `mxint_block_normalise`: stage-2 leading-sign count, min-reduction, clamp, and shift, with its own valid/ready register. Top level holds stage 1, the mode latch, and the tile counter.

## Test plan
- ReLU, NORMALISE=1, exp 2, m [−3, 5, 12, −128] → m [0, 40, 96, 0], exp −1.
- Leaky, shift 2, exp 0, m [−8, −3, 4, 0] → stage 1 [−2, −1, 4, 0], then k=4 → m [−32, −16, 64, 0], exp −4.
- Underflow clamp: ReLU, exp −7, m [1, 0, 0, 0] → k clamped to 1 → m [2, 0, 0, 0], exp −8.
- All-zero block, exp 3 → m all 0, exp 3. Bypass with NORMALISE=0 returns input bit-exact after 2 cycles.
- Backpressure: 16 random blocks, `data_out_ready` toggled pseudo-randomly → output sequence identical to reference model, no loss. `data_out_last` on blocks 4, 8, 12, 16 (4×4 tensor, 2×2 blocks).
- Mode changed mid-tensor is ignored until the next tile 0. `rst` pulsed low mid-tensor → outputs 0, `data_out_valid` 0, and the next block is counted as tile 0.
